// File: rtl/csc_rd_pkg.sv
// Shared definitions for the read-side CSC timing sequencer and the reusable
// video timing counter.
package csc_rd_pkg;

  localparam int TW_W = 16;

  localparam logic [3:0] CS_RGB    = 4'd0;
  localparam logic [3:0] CS_YUV444 = 4'd1;
  localparam logic [3:0] CS_YUV422 = 4'd2;
  localparam logic [3:0] CS_YUV420 = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  typedef logic [TW_W-1:0] tw_t;

  typedef struct packed {
    tw_t hsync;
    tw_t hbp;
    tw_t hact;
    tw_t hfp;
    tw_t vsync;
    tw_t vbp;
    tw_t vact;
    tw_t vfp;
  } timing_cfg_t;

  // Sum of two timing words with one guard bit.
  function automatic logic [TW_W:0] add_w(input tw_t a, input tw_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical beat counters over one frame; shared by the read and
// write sides. Counters sit at zero whenever run is low.
module video_timing_cnt
  import csc_rd_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst,
  input  logic          run,
  input  timing_cfg_t   cfg,
  output logic [TW_W:0] hcnt,
  output logic [TW_W:0] vcnt,
  output logic          frame_end
);

  localparam logic [TW_W:0] ONE = (TW_W+1)'(1);

  logic [TW_W:0] htot;
  logic [TW_W:0] vtot;
  logic          h_last;
  logic          v_last;

  assign htot = add_w(cfg.hsync, cfg.hbp) + add_w(cfg.hact, cfg.hfp);
  assign vtot = add_w(cfg.vsync, cfg.vbp) + add_w(cfg.vact, cfg.vfp);

  assign h_last    = (hcnt == htot - ONE);
  assign v_last    = (vcnt == vtot - ONE);
  assign frame_end = run & h_last & v_last;

  always_ff @(posedge clk_in) begin
    if (rst || !run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + ONE;
    end else begin
      hcnt <= hcnt + ONE;
    end
  end

endmodule

// File: rtl/csc_rd_timing_ctrl.sv
// Read-side CSC sequencer: frame timing, data-fetch enable with YUV420 line-pair
// skipping, and the frame-buffer FIFO pop / underflow handshake.
module csc_rd_timing_ctrl
  import csc_rd_pkg::*;
#(
  parameter int C_PORT_NUM = 4,
  parameter int C_TW       = TW_W,
  parameter bit C_PREFILL  = 1'b1
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            ENABLE_I,
  input  logic [3:0]      ISPACE_I,
  input  logic [C_TW-1:0] HSYNC_I,
  input  logic [C_TW-1:0] HBP_I,
  input  logic [C_TW-1:0] HACT_I,
  input  logic [C_TW-1:0] HFP_I,
  input  logic [C_TW-1:0] VSYNC_I,
  input  logic [C_TW-1:0] VBP_I,
  input  logic [C_TW-1:0] VACT_I,
  input  logic [C_TW-1:0] VFP_I,
  input  logic            FIFO_EMPTY_I,
  output logic            FIFO_RD_EN_O,
  output logic            PIXEL_VS_O,
  output logic            PIXEL_HS_O,
  output logic            PIXEL_DE_O,
  output logic            PIXEL_DE_TOTAL_O,
  output logic            UNDERFLOW_O,
  output logic            BUSY_O
);

  if (C_TW != TW_W) begin : g_tw_check
    $error("C_TW must equal csc_rd_pkg::TW_W");
  end
  if (C_PORT_NUM < 1) begin : g_port_check
    $error("C_PORT_NUM must be at least 1");
  end

  state_e        state;
  timing_cfg_t   cfg;
  timing_cfg_t   cfg_in;
  logic [3:0]    ispace_q;
  logic          run;
  logic          frame_end;
  logic          latch;
  logic [TW_W:0] hcnt;
  logic [TW_W:0] vcnt;
  logic [TW_W:0] h_beg;
  logic [TW_W:0] h_end;
  logic [TW_W:0] v_beg;
  logic [TW_W:0] v_end;
  logic          hs_d;
  logic          vs_d;
  logic          hact_d;
  logic          vact_d;
  logic          det_d;
  logic          fetch_line;
  logic          de_d;

  assign cfg_in = '{hsync: HSYNC_I, hbp: HBP_I, hact: HACT_I, hfp: HFP_I,
                    vsync: VSYNC_I, vbp: VBP_I, vact: VACT_I, vfp: VFP_I};

  assign run   = (state == ST_RUN);
  assign latch = ENABLE_I & ((state == ST_IDLE) | (run & frame_end));

  video_timing_cnt u_cnt (
    .clk_in    (CLK_I),
    .rst       (RST_I),
    .run       (run),
    .cfg       (cfg),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .frame_end (frame_end)
  );

  assign h_beg = add_w(cfg.hsync, cfg.hbp);
  assign h_end = h_beg + {1'b0, cfg.hact};
  assign v_beg = add_w(cfg.vsync, cfg.vbp);
  assign v_end = v_beg + {1'b0, cfg.vact};

  assign hs_d   = (hcnt < {1'b0, cfg.hsync});
  assign vs_d   = (vcnt < {1'b0, cfg.vsync});
  assign hact_d = (hcnt >= h_beg) && (hcnt < h_end);
  assign vact_d = (vcnt >= v_beg) && (vcnt < v_end);
  assign det_d  = hact_d & vact_d;

  // Active-line parity is the LSB of vcnt - v_beg, i.e. the XOR of the two LSBs.
  assign fetch_line = (ispace_q != CS_YUV420) | ~(vcnt[0] ^ v_beg[0]);
  assign de_d       = det_d & fetch_line;

  assign FIFO_RD_EN_O = PIXEL_DE_O & ~FIFO_EMPTY_I;
  assign BUSY_O       = (state != ST_IDLE);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state            <= ST_IDLE;
      cfg              <= '0;
      ispace_q         <= '0;
      PIXEL_VS_O       <= 1'b0;
      PIXEL_HS_O       <= 1'b0;
      PIXEL_DE_O       <= 1'b0;
      PIXEL_DE_TOTAL_O <= 1'b0;
      UNDERFLOW_O      <= 1'b0;
    end else begin
      if (latch) begin
        cfg      <= cfg_in;
        ispace_q <= ISPACE_I;
      end

      case (state)
        ST_IDLE:    if (ENABLE_I) state <= ST_PREFILL;
        ST_PREFILL: if (!C_PREFILL || !FIFO_EMPTY_I) state <= ST_RUN;
        ST_RUN:     if (frame_end && !ENABLE_I) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase

      // Decode lags the counters by one clock and is forced low outside RUN.
      PIXEL_VS_O       <= run & vs_d;
      PIXEL_HS_O       <= run & hs_d;
      PIXEL_DE_O       <= run & de_d;
      PIXEL_DE_TOTAL_O <= run & det_d;

      // A missed fetch beat is not retried; timing free-runs and the flag sticks.
      if (state == ST_IDLE && ENABLE_I)
        UNDERFLOW_O <= 1'b0;
      else if (PIXEL_DE_O && FIFO_EMPTY_I)
        UNDERFLOW_O <= 1'b1;
    end
  end

endmodule
